// File: rtl/add8_result_fifo.sv
// ---------------------------------------------------------------------------
// add8_result_fifo
//
// Collection stage behind the 8-bit adder (add8_normal / add8_pipeline).
// Launched operations are tracked through the adder latency with a valid
// delay line. Each {cout,sum} result is captured into a first-word-fall-through
// FIFO with a ready/valid output. The block also keeps a running 16-bit total
// and a saturating count of results that carried out.
//
// Optional feature macro: ADD8_RES_CHECK_EN
//   When defined, the expected result cina+cinb+cin is computed at launch and
//   carried alongside the valid bit. A mismatch against the adder output sets
//   the sticky err flag. When undefined, err is tied low.
//
// FIFO states (derived from count, no separate state register)
//   state   | meaning
//   EMPTY   | count == 0, out_valid low
//   PARTIAL | 0 < count < DEPTH
//   FULL    | count == DEPTH, a result is accepted only alongside a pop
//
// Parameters
//   LAT       adder result latency in clk_100M edges (1..4)
//   DEPTH     FIFO entries, power of two (2..16)
//
// Ports
//   clk_100M    in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   operation launched into the adder this cycle
//   cin         in   operand carry-in
//   cina        in   operand A [7:0]
//   cinb        in   operand B [7:0]
//   sum         in   adder sum output [7:0]
//   cout        in   adder carry output
//   out_ready   in   consumer accepts the head entry
//   out_valid   out  FIFO not empty
//   out_data    out  FIFO head {cout,sum} [8:0]
//   full        out  FIFO holds DEPTH entries
//   drop        out  sticky: a result was lost because the FIFO was full
//   acc         out  running sum of accepted results, modulo 2^16 [15:0]
//   carry_cnt   out  accepted results with cout=1, saturating at 255 [7:0]
//   err         out  sticky self-check mismatch flag
// ---------------------------------------------------------------------------
module add8_result_fifo #(
    parameter int LAT   = 1,
    parameter int DEPTH = 8
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        cin,
    input  logic [7:0]  cina,
    input  logic [7:0]  cinb,
    input  logic [7:0]  sum,
    input  logic        cout,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [8:0]  out_data,
    output logic        full,
    output logic        drop,
    output logic [15:0] acc,
    output logic [7:0]  carry_cnt,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [LAT-1:0] vld_sr;
    logic           res_vld;
    logic [8:0]     res_word;

    logic [8:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push;
    logic           pop;

    // Valid delay line: the last stage lines up with the adder output.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign res_vld  = vld_sr[LAT-1];
    assign res_word = {cout, sum};

    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes a result when the head leaves on the same edge.
    assign push      = res_vld && (!full || pop);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk_100M) begin
        if (push) begin
            mem[wr_ptr] <= res_word;
        end
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            acc       <= 16'h0000;
            carry_cnt <= 8'h00;
            drop      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push) begin
                acc <= acc + {7'b0, res_word};
                if (cout && (carry_cnt != 8'hFF)) begin
                    carry_cnt <= carry_cnt + 8'd1;
                end
            end
            if (res_vld && !push) begin
                drop <= 1'b1;
            end
        end
    end

`ifdef ADD8_RES_CHECK_EN
    logic [8:0] exp_sr [LAT];
    logic       err_q;

    // Expected result travels with the valid bit so the compare sees the
    // operands that produced the current adder output.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                exp_sr[i] <= 9'h000;
            end
            err_q <= 1'b0;
        end else begin
            exp_sr[0] <= {1'b0, cina} + {1'b0, cinb} + {8'b0, cin};
            for (int i = 1; i < LAT; i++) begin
                exp_sr[i] <= exp_sr[i-1];
            end
            // Checked whether the result is accepted or dropped.
            if (res_vld && (exp_sr[LAT-1] != res_word)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_operands;
    assign unused_operands = ^{cin, cina, cinb};
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_add8_result_fifo.sv
module tb_add8_result_fifo;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

`ifdef ADD8_RES_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic        clk_100M = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic [7:0]  cina = 8'h00;
    logic [7:0]  cinb = 8'h00;
    logic [7:0]  sum;
    logic        cout;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [8:0]  out_data;
    logic        full;
    logic        drop;
    logic [15:0] acc;
    logic [7:0]  carry_cnt;
    logic        err;
    logic        corrupt = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk_100M = ~clk_100M;

    add8_result_fifo #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk_100M  (clk_100M),
        .rst       (rst),
        .in_valid  (in_valid),
        .cin       (cin),
        .cina      (cina),
        .cinb      (cinb),
        .sum       (sum),
        .cout      (cout),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .full      (full),
        .drop      (drop),
        .acc       (acc),
        .carry_cnt (carry_cnt),
        .err       (err)
    );

    // Adder stand-in: LAT registered stages, optional single-bit corruption.
    logic [8:0] add_pipe [LAT];
    always @(posedge clk_100M) begin
        add_pipe[0] <= 9'({1'b0, cina} + {1'b0, cinb} + {8'b0, cin}) ^ {8'b0, corrupt};
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign {cout, sum} = add_pipe[LAT-1];

    // Reference model: launches are scheduled for the edge LAT cycles later,
    // the FIFO is a queue bounded at DEPTH entries.
    typedef struct {
        int unsigned due;
        logic [8:0]  drv;
        logic [8:0]  tru;
    } pend_t;

    pend_t       pend[$];
    logic [8:0]  mq[$];
    logic [15:0] m_acc = 16'h0;
    int          m_carry = 0;
    bit          m_drop = 1'b0;
    bit          m_err = 1'b0;
    int unsigned cyc = 0;
    pend_t       r;
    bit          have;
    bit          mpop;
    logic [8:0]  t9;

    always @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            pend.delete();
            mq.delete();
            m_acc = 16'h0;
            m_carry = 0;
            m_drop = 1'b0;
            m_err = 1'b0;
            cyc = 0;
        end else begin
            have = (pend.size() != 0) && (pend[0].due == cyc);
            if (have) r = pend.pop_front();
            mpop = (mq.size() != 0) && out_ready;
            if (mpop) void'(mq.pop_front());
            if (have) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(r.drv);
                    m_acc = m_acc + 16'(r.drv);
                    if (r.drv[8] && m_carry < 255) m_carry = m_carry + 1;
                end else begin
                    m_drop = 1'b1;
                end
                if (EXP_ERR && (r.drv != r.tru)) m_err = 1'b1;
            end
            if (in_valid) begin
                t9 = 9'({1'b0, cina} + {1'b0, cinb} + {8'b0, cin});
                pend.push_back('{cyc + LAT, t9 ^ {8'b0, corrupt}, t9});
            end
            cyc = cyc + 1;
        end
    end

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; corrupt = 1'b0;
        repeat (2) @(negedge clk_100M);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; cina = 8'hAA; cinb = 8'h55; out_ready = 1'b1;
        repeat (3) @(negedge clk_100M);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
        total++; if (drop !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b want 0", drop); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (acc !== 16'h0000) begin bad++; $display("FAIL reset_acc: got %h want 0000", acc); end
        total++; if (carry_cnt !== 8'h00) begin bad++; $display("FAIL reset_carry: got %h want 00", carry_cnt); end
    endtask

    task automatic test_first_result();
        @(negedge clk_100M);
        in_valid = 1'b1; cina = 8'd255; cinb = 8'd100; cin = 1'b0;
        for (int e = 0; e <= LAT; e++) begin
            @(negedge clk_100M);
            if (e == 0) in_valid = 1'b0;
            if (e < LAT) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_early_valid e=%0d: got %b want 0", e, out_valid); end
            end else begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", out_valid); end
                total++; if (out_data !== 9'h163) begin bad++; $display("FAIL first_data: got %h want 163", out_data); end
                total++; if (acc !== 16'h0163) begin bad++; $display("FAIL first_acc: got %h want 0163", acc); end
                total++; if (carry_cnt !== 8'd1) begin bad++; $display("FAIL first_carry: got %0d want 1", carry_cnt); end
            end
        end
        out_ready = 1'b1;
        @(negedge clk_100M);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_pop: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_tab [3];
        logic [7:0] b_tab [3];
        logic [8:0] d_tab [3];
        a_tab = '{8'd100, 8'd150, 8'd200};
        b_tab = '{8'd100, 8'd150, 8'd100};
        d_tab = '{9'h0C9, 9'h12D, 9'h12D};
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; cina = a_tab[0]; cinb = b_tab[0]; cin = 1'b1;
        for (int e = 0; e <= LAT + 3; e++) begin
            @(negedge clk_100M);
            if (e < 2) begin cina = a_tab[e+1]; cinb = b_tab[e+1]; end
            if (e == 2) in_valid = 1'b0;
            if (e >= LAT && e < LAT + 3) begin
                total++; if (out_valid !== 1'b1 || out_data !== d_tab[e-LAT])
                    begin bad++; $display("FAIL b2b_data%0d: got v=%b d=%h want v=1 d=%h", e - LAT, out_valid, out_data, d_tab[e-LAT]); end
            end
            if (e == LAT + 3) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
                total++; if (carry_cnt !== 8'd2) begin bad++; $display("FAIL b2b_carry: got %0d want 2", carry_cnt); end
                total++; if (acc !== 16'h0323) begin bad++; $display("FAIL b2b_acc: got %h want 0323", acc); end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drop();
        do_reset();
        in_valid = 1'b1; cina = 8'd1; cinb = 8'd1; cin = 1'b0;
        for (int e = 0; e <= DEPTH + LAT; e++) begin
            @(negedge clk_100M);
            if (e == DEPTH) in_valid = 1'b0;
            if (e == DEPTH - 2 + LAT) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_not_full: got %b want 0", full); end
            end
            if (e == DEPTH - 1 + LAT) begin
                total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
                total++; if (drop !== 1'b0) begin bad++; $display("FAIL fill_no_drop: got %b want 0", drop); end
            end
            if (e == DEPTH + LAT) begin
                total++; if (drop !== 1'b1) begin bad++; $display("FAIL fill_drop: got %b want 1", drop); end
                total++; if (acc !== 16'(2 * DEPTH)) begin bad++; $display("FAIL fill_acc: got %0d want %0d", acc, 2 * DEPTH); end
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            total++; if (out_valid !== 1'b1 || out_data !== 9'h002)
                begin bad++; $display("FAIL drain%0d: got v=%b d=%h want v=1 d=002", k, out_valid, out_data); end
            @(negedge clk_100M);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        int exp_acc;
        exp_acc = DEPTH * (DEPTH + 1) / 2 + 9'h101;
        do_reset();
        in_valid = 1'b1; cina = 8'd1; cinb = 8'd0; cin = 1'b0;
        for (int e = 0; e <= DEPTH + LAT; e++) begin
            @(negedge clk_100M);
            if (e < DEPTH - 1) cina = 8'(e + 2);
            if (e == DEPTH - 1) begin cina = 8'h80; cinb = 8'h80; cin = 1'b1; end
            if (e == DEPTH) in_valid = 1'b0;
            if (e == DEPTH + LAT - 1) begin
                total++; if (full !== 1'b1) begin bad++; $display("FAIL fpp_pre_full: got %b want 1", full); end
                out_ready = 1'b1;
            end
            if (e == DEPTH + LAT) begin
                out_ready = 1'b0;
                total++; if (full !== 1'b1) begin bad++; $display("FAIL fpp_full: got %b want 1", full); end
                total++; if (drop !== 1'b0) begin bad++; $display("FAIL fpp_drop: got %b want 0", drop); end
                total++; if (acc !== 16'(exp_acc)) begin bad++; $display("FAIL fpp_acc: got %h want %h", acc, 16'(exp_acc)); end
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            total++; if (out_data !== ((k < DEPTH - 1) ? 9'(k + 2) : 9'h101))
                begin bad++; $display("FAIL fpp_drain%0d: got %h", k, out_data); end
            @(negedge clk_100M);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; cina = 8'd90; cinb = 8'd120; cin = 1'b1;
        @(negedge clk_100M);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        for (int e = 0; e < LAT + 3; e++) begin
            @(negedge clk_100M);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid e=%0d: got %b want 0", e, out_valid); end
        end
        total++; if (acc !== 16'h0000) begin bad++; $display("FAIL midrst_acc: got %h want 0000", acc); end
    endtask

    task automatic test_checker();
        do_reset();
        in_valid = 1'b1; cina = 8'd90; cinb = 8'd120; cin = 1'b1; corrupt = 1'b1;
        for (int e = 0; e <= LAT + 2; e++) begin
            @(negedge clk_100M);
            if (e == 0) begin in_valid = 1'b0; corrupt = 1'b0; end
            if (e < LAT) begin
                total++; if (err !== 1'b0) begin bad++; $display("FAIL chk_early e=%0d: got %b want 0", e, err); end
            end else begin
                total++; if (err !== EXP_ERR) begin bad++; $display("FAIL chk_err e=%0d: got %b want %b", e, err, EXP_ERR); end
            end
            if (e == LAT) begin
                total++; if (out_data !== 9'h0D2) begin bad++; $display("FAIL chk_data: got %h want 0D2", out_data); end
            end
        end
        do_reset();
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL chk_cleared: got %b want 0", err); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; cina = 8'd255; cinb = 8'd255; cin = 1'b1;
        repeat (300) @(negedge clk_100M);
        in_valid = 1'b0;
        repeat (LAT + 2) @(negedge clk_100M);
        total++; if (carry_cnt !== 8'd255) begin bad++; $display("FAIL sat_carry: got %0d want 255", carry_cnt); end
        total++; if (acc !== 16'(300 * 511)) begin bad++; $display("FAIL sat_acc: got %h want %h", acc, 16'(300 * 511)); end
        total++; if (drop !== 1'b0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL sat_flags: got drop=%b valid=%b want 0 0", drop, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk_100M);
            total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid n=%0d: got %b want %b", n, out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                total++; if (out_data !== mq[0]) begin bad++; $display("FAIL rnd_data n=%0d: got %h want %h", n, out_data, mq[0]); end
            end
            total++; if (full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full n=%0d: got %b", n, full); end
            total++; if (drop !== m_drop) begin bad++; $display("FAIL rnd_drop n=%0d: got %b want %b", n, drop, m_drop); end
            total++; if (acc !== m_acc) begin bad++; $display("FAIL rnd_acc n=%0d: got %h want %h", n, acc, m_acc); end
            total++; if (carry_cnt !== 8'(m_carry)) begin bad++; $display("FAIL rnd_carry n=%0d: got %0d want %0d", n, carry_cnt, m_carry); end
            total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d: got %b want %b", n, err, m_err); end
            in_valid  = ($urandom_range(0, 9) < 7);
            cina      = 8'($urandom);
            cinb      = 8'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < ((n < 300) ? 3 : 7));
            corrupt   = ($urandom_range(0, 99) == 0);
        end
        in_valid = 1'b0; out_ready = 1'b0; corrupt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_result();
        test_back_to_back();
        test_fill_drop();
        test_full_push_pop();
        test_reset_mid();
        test_checker();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add8_result_fifo.md
# add8_result_fifo

Downstream collection stage for the 8-bit adder (`add8_normal` / `add8_pipeline`). It tracks launched operations through the adder's latency and captures each `{cout,sum}` result into a first-word-fall-through FIFO. The FIFO has a ready/valid output. The block also keeps a running 16-bit total and a carry counter. It connects directly to the adder's `sum`/`cout` outputs and shares its operand bus.

## Interface
Parameters:
- `LAT`, default 1: adder result latency in `clk_100M` edges. Legal range 1..4 (1 for `add8_normal`, set to match `add8_pipeline` depth otherwise).
- `DEPTH`, default 8: FIFO entries. Power of two, 2..16.

Ports:
- `clk_100M`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: an operation is launched into the adder this cycle.
- `cin`, in, 1: operand carry-in, as driven to the adder.
- `cina`, in, 8: operand A, as driven to the adder.
- `cinb`, in, 8: operand B, as driven to the adder.
- `sum`, in, 8: adder sum output.
- `cout`, in, 1: adder carry output.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_valid`, out, 1: FIFO not empty.
- `out_data`, out, 9: FIFO head, formatted `{cout,sum}`.
- `full`, out, 1: FIFO holds `DEPTH` entries.
- `drop`, out, 1: sticky flag; a result was lost because the FIFO was full.
- `acc`, out, 16: running sum of all accepted results, wraps modulo 2^16.
- `carry_cnt`, out, 8: count of accepted results with `cout=1`, saturates at 255.
- `err`, out, 1: sticky self-check mismatch flag (see Configuration).

## Operation
- **Valid delay line.** `in_valid` enters a `LAT`-stage shift register; `res_vld` is the last stage.
- **Capture.** When `res_vld=1`, `{cout,sum}` is sampled on that edge.
- **Push rule.** A sampled result is written if `!full`, or if `full` and a pop occurs on the same edge.
  - Otherwise the result is discarded and `drop` is set to 1 (held until `rst`).
- **Pop rule.** A pop occurs when `out_valid && out_ready`.
- **Counter update on simultaneous push and pop.** The occupancy count is unchanged and the pointers both advance.
- **Statistics.** These update only on an accepted push:
  - `acc <= acc + {7'b0,cout,sum}`.
  - `carry_cnt` increments if `cout=1` and `carry_cnt != 255`.
  - Dropped results do not update `acc` or `carry_cnt`.
- **Output flags.**
  - `out_data` is the memory word at the read pointer (FWFT).
  - `out_valid = (count != 0)`.
  - `full = (count == DEPTH)`.
  - All of these derive from registered count/pointers.
- **Pointers.** Each is `log2(DEPTH)` bits and wraps naturally. The count is `log2(DEPTH)+1` bits.
- **FIFO states** (defined by count): EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY → PARTIAL on push.
  - PARTIAL → FULL when a push without a pop brings count to DEPTH.
  - FULL → PARTIAL on a pop without an accepted push.
  - PARTIAL → EMPTY when a pop without a push brings count to 0.
- **Reset values.**
  - The delay line clears, so in-flight results are discarded.
  - Pointers and count = 0; `out_valid=0`, `full=0`.
  - `drop=0`, `err=0`, `acc=16'h0000`, `carry_cnt=8'h00`.
  - `out_data` is unspecified while `out_valid=0`.
- **Reset mid-operation.** Asserting `rst` takes effect immediately (asynchronous). Adder results arriving within `LAT` cycles after `rst` deasserts are ignored, because their valid bits were cleared.

## Timing
- Edges are numbered from E0, the edge that samples `in_valid=1` together with the operands.
  - The FIFO write happens at edge E_LAT.
  - `out_valid` rises in the cycle after E_LAT.
  - Launch-to-visible latency is `LAT+1` cycles.
- `acc`, `carry_cnt` and `drop` update at E_LAT.
- A pop at edge P presents the next entry (or `out_valid=0`) in the cycle after P.
- Back-to-back launches (one per cycle) are sustained when `out_ready=1`.

## Configuration
- Macro: `ADD8_RES_CHECK_EN`.
- **Defined:**
  - `exp = cina + cinb + cin` (9-bit) is computed at launch.
  - `exp` is delayed through `LAT` stages alongside `in_valid`.
  - When `res_vld=1`, a mismatch between `exp` and `{cout,sum}` sets `err` (sticky until `rst`).
  - The check applies whether the result is accepted or dropped.
- **Undefined:** no expected-value pipeline is built, and `err` is tied to 0.

## Test plan
- **Reset values and first result:**
  - Hold `rst=1`, then release. All outputs must equal their reset values.
  - Then launch 255+100, cin=0. Required: `out_data=9'h163`, `acc=16'h0163`, `carry_cnt=1`, with `out_valid` rising exactly `LAT+1` cycles after launch.
- **Back-to-back stream:**
  - Launch 100+100+1, then 150+150+1, then 200+100+1, with `out_ready=1`.
  - Required: `out_data` sequence 0C9, 12D, 12D; `carry_cnt=2`; `acc=16'h0323`.
- **Fill and drop:**
  - With `out_ready=0`, launch DEPTH+1 ops of 1+1+0.
  - Required: `full=1` after the DEPTH-th push, `drop=1` after the last one, `acc=2*DEPTH`.
  - Then drain with `out_ready=1`: exactly DEPTH entries, each 9'h002, then `out_valid=0`.
- **Simultaneous push/pop when full:**
  - Start FULL, assert `out_ready=1` in the same cycle as `res_vld=1`.
  - Required: the result is accepted, `drop` stays 0, and count stays DEPTH.
- **Reset mid-flight:**
  - Launch 90+120+1, then pulse `rst` before E_LAT.
  - Required: `out_valid` stays 0 and `acc=0`.
- **Checker (with `ADD8_RES_CHECK_EN`):**
  - Drive `sum` as the bench model's value XOR 8'h01 for one op.
  - Required: `err=1` from E_LAT onward, cleared only by `rst`.
  - Without the macro, the same stimulus must leave `err=0`.
